// File: rtl/prng_range_pkg.sv
// prng_pkg: LFSR tap constants, FSM state type and a parameter legality check for prng_range.
package prng_pkg;

    typedef enum logic {IDLE, STEP} state_e;

    function automatic logic [31:0] taps(input int width);
        return width == 8  ? 32'h0000_00B8 :
               width == 16 ? 32'h0000_B400 :
               width == 24 ? 32'h00E1_0000 : 32'hA300_0000;
    endfunction

    // True when the output window lies in the upper half of the OUT_W range,
    // which is what lets a single subtraction fold a rejected candidate.
    function automatic bit cfg_ok(input longint width, out_w, range, max_tries);
        return (width == 8 || width == 16 || width == 24 || width == 32) &&
               out_w >= 1 && out_w <= width &&
               range > (64'(1) << (out_w - 1)) && range <= (64'(1) << out_w) &&
               max_tries >= 1;
    endfunction

endpackage

// File: rtl/prng_range_if.sv
// prng_range_if: request/valid handshake between game controller, food placer and prng_range.
interface prng_range_if #(parameter int OUT_W = 6);
    logic             request_rand;
    logic             busy;
    logic             rand_valid;
    logic [OUT_W-1:0] random_num;
    modport master (output request_rand, input busy, rand_valid, random_num);
    modport slave  (input request_rand, output busy, rand_valid, random_num);
endinterface

// File: rtl/prng_range_lfsr_step.sv
// lfsr_step: one right-shifting Galois LFSR step with maximal-length taps for WIDTH.
module lfsr_step
    import prng_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] state_i,
    output logic [WIDTH-1:0] next_o
);
    localparam logic [WIDTH-1:0] TAPS = WIDTH'(taps(WIDTH));

    assign next_o = (state_i >> 1) ^ (state_i[0] ? TAPS : '0);
endmodule

// File: rtl/prng_range.sv
// prng_range: LFSR with rejection sampling into [0, RANGE-1] and bounded-try fallback.
// Define PRNG_FREE_RUN_EN to keep the LFSR stepping while IDLE.
module prng_range
    import prng_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int OUT_W     = 6,
    parameter int RANGE     = 48,
    parameter int SEED      = 1,
    parameter int MAX_TRIES = 8
) (
    input  logic         clka,
    input  logic         restart,
    prng_range_if.slave  bus
);
    localparam int              TW       = MAX_TRIES > 1 ? $clog2(MAX_TRIES) : 1;
    localparam logic [WIDTH-1:0] RST_LFSR = SEED == 0 ? WIDTH'(1) : WIDTH'(SEED);
    localparam logic [OUT_W:0]   RANGE_X  = (OUT_W + 1)'(RANGE);
`ifdef PRNG_FREE_RUN_EN
    localparam bit FREE_RUN = 1'b1;
`else
    localparam bit FREE_RUN = 1'b0;
`endif

    if (!cfg_ok(WIDTH, OUT_W, RANGE, MAX_TRIES)) begin : g_bad_cfg
        $error("prng_range: illegal WIDTH/OUT_W/RANGE/MAX_TRIES combination");
    end

    state_e           state_q, state_d;
    logic [WIDTH-1:0] lfsr_q, lfsr_d, lfsr_nx;
    logic [TW-1:0]    tries_q, tries_d;
    logic [OUT_W-1:0] num_q, num_d, cand;
    logic             valid_q, valid_d, accept, give_up;

    lfsr_step #(.WIDTH(WIDTH)) u_step (.state_i(lfsr_q), .next_o(lfsr_nx));

    assign cand    = lfsr_nx[OUT_W-1:0];
    assign accept  = {1'b0, cand} < RANGE_X;
    assign give_up = tries_q == TW'(MAX_TRIES - 1);

    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_q;
        tries_d = tries_q;
        num_d   = num_q;
        valid_d = 1'b0;
        if (state_q == IDLE) begin
            lfsr_d = FREE_RUN ? lfsr_nx : lfsr_q;
            if (bus.request_rand) begin
                state_d = STEP;
                tries_d = '0;
            end
        end else begin
            lfsr_d  = lfsr_nx;
            tries_d = tries_q + 1'b1;
            if (accept || give_up) begin
                state_d = IDLE;
                valid_d = 1'b1;
                // Rejected candidates lie in [RANGE, 2^OUT_W), so one subtraction lands in range.
                num_d   = accept ? cand : cand - RANGE_X[OUT_W-1:0];
            end
        end
    end

    always_ff @(posedge clka) begin
        if (restart) begin
            state_q <= IDLE;
            lfsr_q  <= RST_LFSR;
            tries_q <= '0;
            num_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            tries_q <= tries_d;
            num_q   <= num_d;
            valid_q <= valid_d;
        end
    end

    assign bus.busy       = state_q == STEP;
    assign bus.rand_valid = valid_q;
    assign bus.random_num = num_q;
endmodule

// File: tb/tb_prng_range.sv
// tb_prng_range: directed table-driven bench for prng_range (WIDTH=8, OUT_W=6, RANGE=48, SEED=1).
module tb_prng_range;
    logic clka = 1'b0;
    logic restart = 1'b1;
    int n_checks = 0;
    int n_fail = 0;

    always #5 clka = ~clka;

    prng_range_if #(.OUT_W(6)) bus ();
    prng_range_if #(.OUT_W(6)) bus_fb ();

    prng_range #(.WIDTH(8), .OUT_W(6), .RANGE(48), .SEED(1), .MAX_TRIES(8)) dut (
        .clka(clka), .restart(restart), .bus(bus));
    prng_range #(.WIDTH(8), .OUT_W(6), .RANGE(48), .SEED(1), .MAX_TRIES(1)) dut_fb (
        .clka(clka), .restart(restart), .bus(bus_fb));

    typedef struct {
        logic       req;
        logic       busy;
        logic       valid;
        logic [5:0] num;
    } vec_t;

    vec_t vecs[26];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clka);
        #1;
    endtask

    task automatic check_main(input string tag, input logic b, input logic v, input logic [5:0] n);
        check({tag, " busy"}, 32'(bus.busy), 32'(b));
        check({tag, " valid"}, 32'(bus.rand_valid), 32'(v));
        check({tag, " num"}, 32'(bus.random_num), 32'(n));
    endtask

    task automatic check_fb(input string tag, input logic b, input logic v, input logic [5:0] n);
        check({tag, " busy"}, 32'(bus_fb.busy), 32'(b));
        check({tag, " valid"}, 32'(bus_fb.rand_valid), 32'(v));
        check({tag, " num"}, 32'(bus_fb.random_num), 32'(n));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // LFSR from 0x01: B8(56 rej) 5C(28) 2E(46) 17(23) B3(51 rej) E1(33) C8(8) 64(36) 32(50 rej) 19(25)
        vecs[0]  = '{1'b0, 1'b0, 1'b0, 6'd0};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 6'd0};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 6'd0};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 6'd0};
        vecs[4]  = '{1'b1, 1'b1, 1'b0, 6'd0};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 6'd0};
        vecs[6]  = '{1'b0, 1'b0, 1'b1, 6'd28};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 6'd28};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 6'd28};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 6'd28};
        vecs[10] = '{1'b1, 1'b1, 1'b0, 6'd28};
        vecs[11] = '{1'b1, 1'b0, 1'b1, 6'd46};
        vecs[12] = '{1'b1, 1'b1, 1'b0, 6'd46};
        vecs[13] = '{1'b1, 1'b0, 1'b1, 6'd23};
        vecs[14] = '{1'b1, 1'b1, 1'b0, 6'd23};
        vecs[15] = '{1'b1, 1'b1, 1'b0, 6'd23};
        vecs[16] = '{1'b1, 1'b0, 1'b1, 6'd33};
        vecs[17] = '{1'b1, 1'b1, 1'b0, 6'd33};
        vecs[18] = '{1'b1, 1'b0, 1'b1, 6'd8};
        vecs[19] = '{1'b1, 1'b1, 1'b0, 6'd8};
        vecs[20] = '{1'b0, 1'b0, 1'b1, 6'd36};
        vecs[21] = '{1'b0, 1'b0, 1'b0, 6'd36};
        vecs[22] = '{1'b1, 1'b1, 1'b0, 6'd36};
        vecs[23] = '{1'b1, 1'b1, 1'b0, 6'd36};
        vecs[24] = '{1'b1, 1'b0, 1'b1, 6'd25};
        vecs[25] = '{1'b0, 1'b0, 1'b0, 6'd25};

        bus.request_rand = 1'b0;
        bus_fb.request_rand = 1'b0;
        restart = 1'b1;
        tick;
        tick;
        restart = 1'b0;
        check_main("reset main", 1'b0, 1'b0, 6'd0);
        check_fb("reset fb", 1'b0, 1'b0, 6'd0);

`ifdef PRNG_FREE_RUN_EN
        for (int i = 0; i < 4; i++) begin
            tick;
            check_main($sformatf("free idle%0d", i), 1'b0, 1'b0, 6'd0);
        end
        bus.request_rand = 1'b1;
        tick;
        bus.request_rand = 1'b0;
        check_main("free req", 1'b1, 1'b0, 6'd0);
        tick;
        check_main("free done", 1'b0, 1'b1, 6'd33);
        tick;
        check_main("free hold", 1'b0, 1'b0, 6'd33);
`else
        for (int i = 0; i < 26; i++) begin
            bus.request_rand = vecs[i].req;
            tick;
            check_main($sformatf("vec%0d", i), vecs[i].busy, vecs[i].valid, vecs[i].num);
        end

        bus.request_rand = 1'b1;
        tick;
        bus.request_rand = 1'b0;
        check_main("midrst req", 1'b1, 1'b0, 6'd25);
        restart = 1'b1;
        tick;
        restart = 1'b0;
        check_main("midrst abort", 1'b0, 1'b0, 6'd0);
        tick;
        check_main("midrst quiet", 1'b0, 1'b0, 6'd0);
        bus.request_rand = 1'b1;
        tick;
        bus.request_rand = 1'b0;
        check_main("midrst again req", 1'b1, 1'b0, 6'd0);
        tick;
        check_main("midrst again step", 1'b1, 1'b0, 6'd0);
        tick;
        check_main("midrst again done", 1'b0, 1'b1, 6'd28);

        bus_fb.request_rand = 1'b1;
        tick;
        bus_fb.request_rand = 1'b0;
        check_fb("fb req", 1'b1, 1'b0, 6'd0);
        tick;
        check_fb("fb fold", 1'b0, 1'b1, 6'd8);
        tick;
        check_fb("fb hold", 1'b0, 1'b0, 6'd8);
        bus_fb.request_rand = 1'b1;
        tick;
        bus_fb.request_rand = 1'b0;
        check_fb("fb req2", 1'b1, 1'b0, 6'd8);
        tick;
        check_fb("fb accept2", 1'b0, 1'b1, 6'd28);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
